slc3_control: RTL and testbench

Moore-style instruction sequencer for the SLC-3 datapath. Issues every load, gate, mux-select and memory strobe the datapath needs to fetch, decode and execute one LC-3-subset instruction at a time. Inserts a parameterised number of memory wait cycles on every SRAM access. Sits beside `datapath` inside the processor top; its only inputs from the datapath are opcode and status bits.

---
 rtl/slc3_pkg.sv | 93 +++++++++
 rtl/slc3_control_if.sv | 28 ++
 rtl/mem_wait_ctr.sv | 24 ++
 rtl/slc3_control.sv | 100 ++++++++++
 tb/tb_slc3_control.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// slc3_pkg: shared state, opcode and datapath-select encodings for the SLC-3 sequencer.
// Revision 1.0
package slc3_pkg;

  typedef enum logic [4:0] {
    ST_HALTED, ST_S18, ST_S33, ST_S35, ST_S32,
    ST_S01, ST_S05, ST_S09,
    ST_S06, ST_S25, ST_S27,
    ST_S07, ST_S23, ST_S16,
    ST_S04, ST_S21, ST_S12,
    ST_S00, ST_S22,
    ST_PAUSE1, ST_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe, mem_we;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mem_oe: 1'b1, mem_we: 1'b1, default: '0};

  // mem_last marks the final cycle of a read wait, the only one that loads MDR.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic ir5, input logic mem_last);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      ST_S18: begin
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PCMUX_PC1; c.ld_pc = 1'b1;
      end
      ST_S33, ST_S25: begin
        c.mem_oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = mem_last;
      end
      ST_S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      ST_S32: c.ld_ben = 1'b1;
      ST_S01, ST_S05: begin
        c.sr1mux = 1'b1; c.sr2mux = ir5;
        c.aluk = (s == ST_S05) ? ALUK_AND : ALUK_ADD;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      ST_S09: begin
        c.sr1mux = 1'b1; c.aluk = ALUK_NOT;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      ST_S06, ST_S07: begin
        c.addr1mux = 1'b1; c.addr2mux = ADDR2_OFF6; c.sr1mux = 1'b1;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
      end
      ST_S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      ST_S23: begin c.aluk = ALUK_PASSA; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
      ST_S16: c.mem_we = 1'b0;
      ST_S04: begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
      ST_S21: begin c.addr2mux = ADDR2_OFF11; c.pcmux = PCMUX_ADDR; c.ld_pc = 1'b1; end
      ST_S12: begin
        c.sr1mux = 1'b1; c.aluk = ALUK_PASSA; c.gate_alu = 1'b1;
        c.pcmux = PCMUX_BUS; c.ld_pc = 1'b1;
      end
      ST_S22: begin c.addr2mux = ADDR2_OFF9; c.pcmux = PCMUX_ADDR; c.ld_pc = 1'b1; end
      ST_PAUSE1: c.ld_led = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slc3_control_if.sv
`timescale 1ns/1ps
`default_nettype none
// slc3_control_if: opcode/status inputs and control strobes between sequencer and datapath.
// Revision 1.0
interface slc3_control_if;
  logic       Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE
  );
endinterface
`default_nettype wire

// File: rtl/mem_wait_ctr.sv
`timescale 1ns/1ps
`default_nettype none
// mem_wait_ctr: 3-bit load/decrement counter timing SRAM wait states; done when it reads 0.
// Revision 1.0
module mem_wait_ctr #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  output logic [2:0] count,
  output logic       done
);
  localparam logic [2:0] C_LOAD = 3'(MEM_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               count <= '0;
    else if (load)         count <= C_LOAD;
    else if (count != '0)  count <= count - 3'd1;
  end

  assign done = (count == '0);
endmodule
`default_nettype wire

// File: rtl/slc3_control.sv
`timescale 1ns/1ps
`default_nettype none
// slc3_control: Moore sequencer fetching, decoding and executing one LC-3-subset instruction.
// Revision 1.0
module slc3_control
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  slc3_control_if.master bus
);
  state_t     state, state_next;
  ctrl_t      ctrl;
  logic       ctr_load, ctr_done, mem_last_next;
  logic [2:0] ctr_count;
  logic       unused_ir11;

  assign unused_ir11 = bus.IR_11;

  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk(Clk), .rst(Reset), .load(ctr_load), .count(ctr_count), .done(ctr_done)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_HALTED: if (bus.Run) state_next = ST_S18;
      ST_S18:    state_next = ST_S33;
      ST_S33:    if (ctr_done) state_next = ST_S35;
      ST_S35:    state_next = ST_S32;
      ST_S32: begin
        case (bus.Opcode)
          OP_ADD:   state_next = ST_S01;
          OP_AND:   state_next = ST_S05;
          OP_NOT:   state_next = ST_S09;
          OP_LDR:   state_next = ST_S06;
          OP_STR:   state_next = ST_S07;
          OP_JSR:   state_next = ST_S04;
          OP_JMP:   state_next = ST_S12;
          OP_BR:    state_next = ST_S00;
          OP_PAUSE: state_next = ST_PAUSE1;
          default:  state_next = ST_S18;
        endcase
      end
      ST_S06:    state_next = ST_S25;
      ST_S25:    if (ctr_done) state_next = ST_S27;
      ST_S07:    state_next = ST_S23;
      ST_S23:    state_next = ST_S16;
      ST_S16:    if (ctr_done) state_next = ST_S18;
      ST_S04:    state_next = ST_S21;
      ST_S00:    state_next = bus.BEN ? ST_S22 : ST_S18;
      ST_PAUSE1: if (bus.Continue) state_next = ST_PAUSE2;
      ST_PAUSE2: if (!bus.Continue) state_next = ST_S18;
      ST_S01, ST_S05, ST_S09, ST_S27, ST_S21, ST_S12, ST_S22: state_next = ST_S18;
      default:   state_next = ST_HALTED;
    endcase
  end

  // Outputs are registered from the next state, so the last-cycle flag is judged one cycle ahead.
  always_comb begin
    ctr_load      = (state_next inside {ST_S33, ST_S25, ST_S16}) && (state_next != state);
    mem_last_next = ctr_load ? (MEM_WAIT == 0) : (ctr_count == 3'd1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_HALTED;
      ctrl  <= CTRL_IDLE;
    end else begin
      state <= state_next;
      ctrl  <= ctrl_decode(state_next, bus.IR_5, mem_last_next);
    end
  end

  assign bus.LD_MAR     = ctrl.ld_mar;
  assign bus.LD_MDR     = ctrl.ld_mdr;
  assign bus.LD_IR      = ctrl.ld_ir;
  assign bus.LD_BEN     = ctrl.ld_ben;
  assign bus.LD_CC      = ctrl.ld_cc;
  assign bus.LD_REG     = ctrl.ld_reg;
  assign bus.LD_PC      = ctrl.ld_pc;
  assign bus.LD_LED     = ctrl.ld_led;
  assign bus.GatePC     = ctrl.gate_pc;
  assign bus.GateMDR    = ctrl.gate_mdr;
  assign bus.GateALU    = ctrl.gate_alu;
  assign bus.GateMARMUX = ctrl.gate_marmux;
  assign bus.PCMUX      = ctrl.pcmux;
  assign bus.ADDR2MUX   = ctrl.addr2mux;
  assign bus.ALUK       = ctrl.aluk;
  assign bus.DRMUX      = ctrl.drmux;
  assign bus.SR1MUX     = ctrl.sr1mux;
  assign bus.SR2MUX     = ctrl.sr2mux;
  assign bus.ADDR1MUX   = ctrl.addr1mux;
  assign bus.MIO_EN     = ctrl.mio_en;
  assign bus.Mem_OE     = ctrl.mem_oe;
  assign bus.Mem_WE     = ctrl.mem_we;
endmodule
`default_nettype wire

// File: tb/tb_slc3_control.sv
`timescale 1ns/1ps
`default_nettype none
// tb_slc3_control: checks two sequencers (MEM_WAIT=2 and 0) against per-instruction output sequences.
module tb_slc3_control;
  logic       clk = 1'b0;
  logic       rst, run, cont, ir5, ir11, ben;
  logic [3:0] opcode;

  always #5 clk = ~clk;

  slc3_control_if if2();
  slc3_control_if if0();

  assign if2.Run = run;   assign if2.Continue = cont; assign if2.Opcode = opcode;
  assign if2.IR_5 = ir5;  assign if2.IR_11 = ir11;    assign if2.BEN = ben;
  assign if0.Run = run;   assign if0.Continue = cont; assign if0.Opcode = opcode;
  assign if0.IR_5 = ir5;  assign if0.IR_11 = ir11;    assign if0.BEN = ben;

  slc3_control #(.MEM_WAIT(2)) u_dut2 (.Clk(clk), .Reset(rst), .bus(if2.master));
  slc3_control #(.MEM_WAIT(0)) u_dut0 (.Clk(clk), .Reset(rst), .bus(if0.master));

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe, mem_we;
  } obs_t;

  obs_t obs2, obs0;
  assign obs2 = {if2.LD_MAR, if2.LD_MDR, if2.LD_IR, if2.LD_BEN, if2.LD_CC, if2.LD_REG, if2.LD_PC,
                 if2.LD_LED, if2.GatePC, if2.GateMDR, if2.GateALU, if2.GateMARMUX, if2.PCMUX,
                 if2.ADDR2MUX, if2.ALUK, if2.DRMUX, if2.SR1MUX, if2.SR2MUX, if2.ADDR1MUX,
                 if2.MIO_EN, if2.Mem_OE, if2.Mem_WE};
  assign obs0 = {if0.LD_MAR, if0.LD_MDR, if0.LD_IR, if0.LD_BEN, if0.LD_CC, if0.LD_REG, if0.LD_PC,
                 if0.LD_LED, if0.GatePC, if0.GateMDR, if0.GateALU, if0.GateMARMUX, if0.PCMUX,
                 if0.ADDR2MUX, if0.ALUK, if0.DRMUX, if0.SR1MUX, if0.SR2MUX, if0.ADDR1MUX,
                 if0.MIO_EN, if0.Mem_OE, if0.Mem_WE};

  int   checks = 0;
  int   passes = 0;
  obs_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  function automatic obs_t cur(input int mw);
    return (mw == 0) ? obs0 : obs2;
  endfunction

  function automatic obs_t dflt();
    obs_t o = '0;
    o.mem_oe = 1'b1; o.mem_we = 1'b1;
    return o;
  endfunction

  function automatic obs_t fetch_start();
    obs_t o = dflt();
    o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1;
    return o;
  endfunction

  function automatic void push_read(input int mw);
    for (int i = 0; i <= mw; i++) begin
      obs_t o = dflt();
      o.mem_oe = 1'b0; o.mio_en = 1'b1; o.ld_mdr = (i == mw);
      exp_q.push_back(o);
    end
  endfunction

  // Expected per-cycle outputs for one instruction, from its fetch start to its last execute cycle.
  function automatic void build(input logic [3:0] op, input logic i5, input logic b, input int mw);
    obs_t o;
    exp_q.delete();
    exp_q.push_back(fetch_start());
    push_read(mw);
    o = dflt(); o.gate_mdr = 1'b1; o.ld_ir = 1'b1; exp_q.push_back(o);
    o = dflt(); o.ld_ben = 1'b1; exp_q.push_back(o);
    case (op)
      4'b0001, 4'b0101: begin
        o = dflt(); o.sr1mux = 1'b1; o.sr2mux = i5; o.aluk = (op == 4'b0101) ? 2'b01 : 2'b00;
        o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1; exp_q.push_back(o);
      end
      4'b1001: begin
        o = dflt(); o.sr1mux = 1'b1; o.aluk = 2'b10;
        o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1; exp_q.push_back(o);
      end
      4'b0110, 4'b0111: begin
        o = dflt(); o.addr1mux = 1'b1; o.addr2mux = 2'b01; o.sr1mux = 1'b1;
        o.gate_marmux = 1'b1; o.ld_mar = 1'b1; exp_q.push_back(o);
        if (op == 4'b0110) begin
          push_read(mw);
          o = dflt(); o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1; exp_q.push_back(o);
        end else begin
          o = dflt(); o.aluk = 2'b11; o.gate_alu = 1'b1; o.ld_mdr = 1'b1; exp_q.push_back(o);
          for (int i = 0; i <= mw; i++) begin
            o = dflt(); o.mem_we = 1'b0; exp_q.push_back(o);
          end
        end
      end
      4'b0100: begin
        o = dflt(); o.gate_pc = 1'b1; o.drmux = 1'b1; o.ld_reg = 1'b1; exp_q.push_back(o);
        o = dflt(); o.addr2mux = 2'b11; o.pcmux = 2'b10; o.ld_pc = 1'b1; exp_q.push_back(o);
      end
      4'b1100: begin
        o = dflt(); o.sr1mux = 1'b1; o.aluk = 2'b11; o.gate_alu = 1'b1;
        o.pcmux = 2'b01; o.ld_pc = 1'b1; exp_q.push_back(o);
      end
      4'b0000: begin
        exp_q.push_back(dflt());
        if (b) begin
          o = dflt(); o.addr2mux = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1'b1; exp_q.push_back(o);
        end
      end
      default: ;
    endcase
  endfunction

  // Called while the fetch-start cycle is visible; leaves the bench on the next fetch start.
  task automatic do_instr(input logic [3:0] op, input logic i5, input logic b, input int mw);
    opcode = op; ir5 = i5; ben = b; ir11 = 1'($urandom_range(0, 1));
    build(op, i5, b, mw);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("seq op=%b cyc=%0d mw=%0d", op, i, mw), cur(mw), exp_q[i]);
    end
    @(negedge clk);
    check($sformatf("next_fetch op=%b mw=%0d", op, mw), cur(mw), fetch_start());
  endtask

  task automatic measure(output int len, output int nreg, output int npc, input int mw);
    obs_t o;
    len = 1; nreg = 0; npc = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      o = cur(mw);
      if (o.gate_pc && o.ld_mar) return;
      len++; nreg += int'(o.ld_reg); npc += int'(o.ld_pc);
    end
    len = -1;
  endtask

  task automatic start();
    rst = 1'b1; run = 1'b0; cont = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op; logic i5; logic b; int len; int nreg; int npc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int len, nreg, npc;
    logic [3:0] rop;
    tbl[0] = '{4'b0001, 1'b1, 1'b0,  7, 1, 1};
    tbl[1] = '{4'b0101, 1'b0, 1'b0,  7, 1, 1};
    tbl[2] = '{4'b1001, 1'b0, 1'b0,  7, 1, 1};
    tbl[3] = '{4'b0110, 1'b0, 1'b0, 11, 1, 1};
    tbl[4] = '{4'b0111, 1'b0, 1'b0, 11, 0, 1};
    tbl[5] = '{4'b0100, 1'b0, 1'b0,  8, 1, 2};
    tbl[6] = '{4'b1100, 1'b0, 1'b0,  7, 0, 2};
    tbl[7] = '{4'b0000, 1'b0, 1'b1,  8, 0, 2};
    tbl[8] = '{4'b0000, 1'b0, 1'b0,  7, 0, 1};
    tbl[9] = '{4'b1111, 1'b0, 1'b0,  6, 0, 1};

    rst = 1'b1; run = 1'b0; cont = 1'b0; opcode = '0; ir5 = 1'b0; ir11 = 1'b0; ben = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_mw2", obs2, dflt());
    check("reset_mw0", obs0, dflt());
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("halted_no_run", obs2, dflt());

    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("run_to_fetch", obs2, fetch_start());

    foreach (tbl[i]) begin
      opcode = tbl[i].op; ir5 = tbl[i].i5; ben = tbl[i].b;
      measure(len, nreg, npc, 2);
      check($sformatf("len op=%b ben=%b", tbl[i].op, tbl[i].b), len, tbl[i].len);
      check($sformatf("ld_reg op=%b", tbl[i].op), nreg, tbl[i].nreg);
      check($sformatf("ld_pc op=%b ben=%b", tbl[i].op, tbl[i].b), npc, tbl[i].npc);
    end

    do_instr(4'b0001, 1'b1, 1'b0, 2);
    do_instr(4'b0000, 1'b0, 1'b1, 2);
    do_instr(4'b0000, 1'b0, 1'b0, 2);
    do_instr(4'b1111, 1'b0, 1'b0, 2);

    // PAUSE with Continue already high: one step into the second pause state, then hold.
    opcode = 4'b1101; cont = 1'b1;
    repeat (6) @(negedge clk);
    begin
      obs_t o = dflt();
      o.ld_led = 1'b1;
      check("pause1_led", obs2, o);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("pause2_hold%0d", i), obs2, dflt());
    end
    cont = 1'b0;
    @(negedge clk);
    check("pause_release", obs2, fetch_start());

    repeat (30) begin
      do rop = 4'($urandom_range(0, 15)); while (rop == 4'b1101);
      do_instr(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
    end

    // Asynchronous reset in the middle of a store's write wait.
    opcode = 4'b0111;
    repeat (9) @(negedge clk);
    check("str_wait_we", 32'(obs2.mem_we), 32'd0);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs", obs2, dflt());
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("halted_after_abort", obs2, dflt());

    start();
    check("mw0_fetch", obs0, fetch_start());
    do_instr(4'b0110, 1'b0, 1'b0, 0);
    repeat (30) begin
      do rop = 4'($urandom_range(0, 15)); while (rop == 4'b1101);
      do_instr(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
